// File: rtl/cordic_pkg.sv
// Shared Q-format constants and the arctangent table for the CORDIC angle-prep block and engine.
package cordic_pkg;

    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_FRAC_BITS  = 14;
    localparam int ATAN_STEPS     = 16;

    // Reference values held in Q.16 and rounded down to the requested fraction width.
    localparam longint PI_Q16     = 64'sd205887;
    localparam longint K_GAIN_Q16 = 64'sd39797;

    function automatic longint q_scale(input longint q16, input int frac);
        return ((q16 <<< frac) + 64'sd32768) >>> 16;
    endfunction

    function automatic longint q_pi(input int frac);
        return q_scale(PI_Q16, frac);
    endfunction

    function automatic longint q_half_pi(input int frac);
        return q_pi(frac) / 2;
    endfunction

    function automatic longint q_two_pi(input int frac);
        return q_pi(frac) * 2;
    endfunction

    function automatic longint q_k_gain(input int frac);
        return q_scale(K_GAIN_Q16, frac);
    endfunction

    // atan(2^-i) in Q3.14.
    function automatic int atan_q14(input int i);
        case (i)
            0:       return 12868;
            1:       return 7596;
            2:       return 4014;
            3:       return 2037;
            4:       return 1023;
            5:       return 512;
            6:       return 256;
            7:       return 128;
            8:       return 64;
            9:       return 32;
            10:      return 16;
            11:      return 8;
            12:      return 4;
            13:      return 2;
            14:      return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_credit_ctr.sv
// Credit counter: gates acceptance on free downstream slots, flags returns beyond capacity.
// Zero latency from credits to ready; credit_err is a registered one-cycle pulse.
module cordic_credit_ctr #(
    parameter int MAX_CREDITS = 16,
    parameter int CREDIT_W    = $clog2(MAX_CREDITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic                credit_return,
    output logic                ready,
    output logic                accept,
    output logic [CREDIT_W-1:0] credits,
    output logic                credit_err
);

    logic full;

    assign ready  = (credits != '0);
    assign accept = valid_in & ready;
    assign full   = (credits == CREDIT_W'(MAX_CREDITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits    <= CREDIT_W'(MAX_CREDITS);
            credit_err <= 1'b0;
        end else begin
            // A simultaneous accept and return cancel out.
            if (accept && !credit_return)
                credits <= credits - CREDIT_W'(1);
            else if (credit_return && !accept && !full)
                credits <= credits + CREDIT_W'(1);
            credit_err <= credit_return & ~accept & full;
        end
    end

endmodule

// File: rtl/cordic_angle_prep.sv
// Range-reduces a Q3.14 angle (2*pi wrap, pi/2 fold) and emits K-scaled CORDIC start vectors.
// Two-cycle latency, one sample per cycle; issue throttled by downstream credits, no stall.
module cordic_angle_prep
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRAC_BITS   = DEF_FRAC_BITS,
    parameter int MAX_CREDITS = 16,
    localparam int CREDIT_W   = $clog2(MAX_CREDITS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] in_theta,
    input  logic                  i_valid_in,
    output logic                  o_ready,
    input  logic                  i_credit_return,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_alpha,
    output logic                  o_valid_out,
    output logic [CREDIT_W-1:0]   o_credits,
    output logic                  o_credit_err
);

    localparam logic signed [DATA_WIDTH:0]   PI_W      = (DATA_WIDTH+1)'(q_pi(FRAC_BITS));
    localparam logic signed [DATA_WIDTH:0]   TWO_PI_W  = (DATA_WIDTH+1)'(q_two_pi(FRAC_BITS));
    localparam logic signed [DATA_WIDTH-1:0] HALF_PI_D = DATA_WIDTH'(q_half_pi(FRAC_BITS));
    localparam logic signed [DATA_WIDTH-1:0] K_GAIN_D  = DATA_WIDTH'(q_k_gain(FRAC_BITS));

    logic                         accept;
    logic signed [DATA_WIDTH:0]   theta_ext;
    logic signed [DATA_WIDTH:0]   wrapped;
    logic                         s1_vld;
    logic signed [DATA_WIDTH-1:0] s1_w;
    logic signed [DATA_WIDTH-1:0] fold_x, fold_y, fold_alpha;

    cordic_credit_ctr #(
        .MAX_CREDITS (MAX_CREDITS),
        .CREDIT_W    (CREDIT_W)
    ) u_credit (
        .clk           (i_clk),
        .rst_n         (i_rst_n),
        .valid_in      (i_valid_in),
        .credit_return (i_credit_return),
        .ready         (o_ready),
        .accept        (accept),
        .credits       (o_credits),
        .credit_err    (o_credit_err)
    );

    // One wrap step covers the whole input range since |theta| < 3*pi.
    always_comb begin
        theta_ext = $signed({in_theta[DATA_WIDTH-1], in_theta});
        wrapped   = theta_ext;
        if (theta_ext > PI_W)
            wrapped = theta_ext - TWO_PI_W;
        else if (theta_ext < -PI_W)
            wrapped = theta_ext + TWO_PI_W;
    end

    always_comb begin
        fold_x     = K_GAIN_D;
        fold_y     = '0;
        fold_alpha = s1_w;
        if (s1_w > HALF_PI_D) begin
            fold_x     = '0;
            fold_y     = K_GAIN_D;
            fold_alpha = s1_w - HALF_PI_D;
        end else if (s1_w < -HALF_PI_D) begin
            fold_x     = '0;
            fold_y     = -K_GAIN_D;
            fold_alpha = s1_w + HALF_PI_D;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld      <= 1'b0;
            s1_w        <= '0;
            o_valid_out <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_alpha   <= '0;
        end else begin
            s1_vld      <= accept;
            o_valid_out <= s1_vld;
            if (accept)
                s1_w <= wrapped[DATA_WIDTH-1:0];
            if (s1_vld) begin
                out_x     <= fold_x;
                out_y     <= fold_y;
                out_alpha <= fold_alpha;
            end
        end
    end

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Scoreboard bench for cordic_angle_prep: directed angle cases, credit corners, random traffic, reset flush.
module tb_cordic_angle_prep;

    localparam int DW   = 18;
    localparam int CW   = 5;
    localparam int MAXC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] theta = '0;
    logic          vin = 1'b0;
    logic          ret = 1'b0;
    logic          o_ready, o_valid_out, o_credit_err;
    logic [DW-1:0] out_x, out_y, out_alpha;
    logic [CW-1:0] o_credits;

    typedef struct {
        int x;
        int y;
        int a;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   credits = MAXC;
    bit   exp_err = 1'b0;

    cordic_angle_prep #(.DATA_WIDTH(DW), .FRAC_BITS(14), .MAX_CREDITS(MAXC)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .in_theta        (theta),
        .i_valid_in      (vin),
        .o_ready         (o_ready),
        .i_credit_return (ret),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_alpha       (out_alpha),
        .o_valid_out     (o_valid_out),
        .o_credits       (o_credits),
        .o_credit_err    (o_credit_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Angle reduction computed straight from radians arithmetic in Q3.14 integers.
    function automatic void ref_model(input int th, output int x, output int y, output int a);
        int w;
        w = th;
        if (w > 51472)       w = w - 102944;
        else if (w < -51472) w = w + 102944;
        if (w > 25736) begin
            x = 0; y = 9949; a = w - 25736;
        end else if (w < -25736) begin
            x = 0; y = -9949; a = w + 25736;
        end else begin
            x = 9949; y = 0; a = w;
        end
    endfunction

    // Called at posedge+#1: checks credit state, then drives one cycle of inputs.
    task automatic step(input bit v, input int th, input bit r);
        bit   acc;
        exp_t e;
        check("credits", int'(o_credits), credits);
        check("ready", int'(o_ready), int'(credits != 0));
        check("credit_err", int'(o_credit_err), int'(exp_err));
        vin   = v;
        theta = DW'(th);
        ret   = r;
        acc   = v && (credits > 0);
        exp_err = r && !acc && (credits == MAXC);
        if (acc) begin
            ref_model(th, e.x, e.y, e.a);
            e.due = cyc + 2;
            sb.push_back(e);
        end
        if (acc && !r)                          credits--;
        else if (r && !acc && credits < MAXC)   credits++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", int'(o_valid_out), 0);
        check("rst_x", int'(out_x), 0);
        check("rst_y", int'(out_y), 0);
        check("rst_alpha", int'(out_alpha), 0);
        check("rst_credits", int'(o_credits), MAXC);
        check("rst_ready", int'(o_ready), 1);
        check("rst_err", int'(o_credit_err), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", int'(o_valid_out), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("x", int'($signed(out_x)), e.x);
                    check("y", int'($signed(out_y)), e.y);
                    check("alpha", int'($signed(out_alpha)), e.a);
                    check("latency", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("missing_valid", int'(o_valid_out), 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dir[] = '{0, 32768, -32768, 114688, -131072, 25736, 51472, -51472,
                      -25736, -25737, 25737, 131071};
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (dir[i]) step(1'b1, dir[i], 1'b1);
        repeat (3) step(1'b0, 0, 1'b0);

        // Exhaust credits: 17 back-to-back valids, the last one must be ignored.
        for (int i = 0; i < 17; i++) step(1'b1, i * 1000 - 8000, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 777, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic signed [DW-1:0] t;
            int pv, pr;
            t  = DW'($urandom);
            pv = (i < 200) ? 70 : 40;
            pr = (i < 200) ? 40 : 70;
            step($urandom_range(0, 99) < pv, int'(t), $urandom_range(0, 99) < pr);
        end
        repeat (4) step(1'b0, 0, 1'b0);

        // Reset with two samples in flight: they must never appear.
        step(1'b1, 1234, 1'b0);
        step(1'b1, -4321, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        credits = MAXC;
        exp_err = 1'b0;
        #2;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) step(1'b0, 0, 1'b0);
        step(1'b1, 40000, 1'b1);
        repeat (4) step(1'b0, 0, 1'b0);

        check("drain_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
